// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the MIPS-subset pipeline.
//
// Reads rs/rt from an internal 32x32 register file (r0 hard-wired to zero,
// write-back forwarding), decodes control signals and immediates from the
// fetched instruction, and registers the result into the ID/EX register.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   if_inst, if_pc4, if_valid   fetched instruction, its PC+4, live flag
//   stall, flush                hold / bubble the ID/EX register (flush wins)
//   wb_we, wb_addr, wb_data     register-file write-back port
//   id_*                        ID/EX pipeline register contents
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc4,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc4,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_shamt,
  output logic [4:0]  id_dst,
  output logic [3:0]  id_alu_op,
  output logic        id_alu_src_imm,
  output logic        id_mem_rd,
  output logic        id_mem_wr,
  output logic        id_reg_we,
  output logic        id_beq,
  output logic        id_bne,
  output logic        id_jump,
  output logic [31:0] id_jump_target,
  output logic        id_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [31:0] regs [0:31];

  // Indices of the latched instruction, kept so a stall can re-read operands.
  logic [4:0] id_rs_idx;
  logic [4:0] id_rt_idx;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  alu_op_e     dec_alu_op;
  logic [31:0] dec_imm;
  logic [4:0]  dec_dst;
  logic        dec_src_imm;
  logic        dec_mem_rd;
  logic        dec_mem_wr;
  logic        dec_reg_we;
  logic        dec_beq;
  logic        dec_bne;
  logic        dec_jump;
  logic        dec_illegal;

  assign opcode   = if_inst[31:26];
  assign funct    = if_inst[5:0];
  assign rs_idx   = if_inst[25:21];
  assign rt_idx   = if_inst[20:16];
  assign rd_idx   = if_inst[15:11];
  assign imm_sext = {{16{if_inst[15]}}, if_inst[15:0]};
  assign imm_zext = {16'h0000, if_inst[15:0]};

  // Combinational read with write-back forwarding; r0 always reads zero.
  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0)
      return '0;
    if (wb_we && (wb_addr == idx))
      return wb_data;
    return regs[idx];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    dec_alu_op  = ALU_ADD;
    dec_imm     = '0;
    dec_dst     = '0;
    dec_src_imm = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_reg_we  = 1'b0;
    dec_beq     = 1'b0;
    dec_bne     = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        dec_dst    = rd_idx;
        dec_reg_we = 1'b1;
        case (funct)
          6'b100000: dec_alu_op = ALU_ADD;
          6'b100010: dec_alu_op = ALU_SUB;
          6'b100100: dec_alu_op = ALU_AND;
          6'b100101: dec_alu_op = ALU_OR;
          6'b100110: dec_alu_op = ALU_XOR;
          6'b100111: dec_alu_op = ALU_NOR;
          6'b101010: dec_alu_op = ALU_SLT;
          6'b000000: dec_alu_op = ALU_SLL;
          6'b000010: dec_alu_op = ALU_SRL;
          default: begin
            dec_reg_we  = 1'b0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        dec_dst     = rt_idx;
        dec_reg_we  = 1'b1;
        dec_src_imm = 1'b1;
        case (opcode)
          OP_ANDI: begin dec_alu_op = ALU_AND; dec_imm = imm_zext; end
          OP_ORI:  begin dec_alu_op = ALU_OR;  dec_imm = imm_zext; end
          OP_XORI: begin dec_alu_op = ALU_XOR; dec_imm = imm_zext; end
          OP_LUI:  begin dec_alu_op = ALU_LUI; dec_imm = {if_inst[15:0], 16'h0000}; end
          default: begin dec_alu_op = ALU_ADD; dec_imm = imm_sext; end
        endcase
        dec_mem_rd = (opcode == OP_LW);
      end
      OP_SW: begin
        dec_mem_wr  = 1'b1;
        dec_src_imm = 1'b1;
        dec_imm     = imm_sext;
      end
      OP_BEQ: begin
        dec_alu_op = ALU_SUB;
        dec_beq    = 1'b1;
        dec_imm    = imm_sext;
      end
      OP_BNE: begin
        dec_alu_op = ALU_SUB;
        dec_bne    = 1'b1;
        dec_imm    = imm_sext;
      end
      OP_J: begin
        dec_jump = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase

    // A bubble from fetch must not carry any side-effecting control.
    if (!if_valid) begin
      dec_src_imm = 1'b0;
      dec_mem_rd  = 1'b0;
      dec_mem_wr  = 1'b0;
      dec_reg_we  = 1'b0;
      dec_beq     = 1'b0;
      dec_bne     = 1'b0;
      dec_jump    = 1'b0;
      dec_illegal = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      id_valid       <= 1'b0;
      id_pc4         <= '0;
      id_rs_data     <= '0;
      id_rt_data     <= '0;
      id_imm         <= '0;
      id_shamt       <= '0;
      id_dst         <= '0;
      id_alu_op      <= '0;
      id_alu_src_imm <= 1'b0;
      id_mem_rd      <= 1'b0;
      id_mem_wr      <= 1'b0;
      id_reg_we      <= 1'b0;
      id_beq         <= 1'b0;
      id_bne         <= 1'b0;
      id_jump        <= 1'b0;
      id_jump_target <= '0;
      id_illegal     <= 1'b0;
      id_rs_idx      <= '0;
      id_rt_idx      <= '0;
    end else if (stall) begin
      // Decoded fields hold; operands re-read so write-backs during the stall land.
      id_rs_data <= rf_read(id_rs_idx);
      id_rt_data <= rf_read(id_rt_idx);
    end else begin
      id_valid       <= if_valid;
      id_pc4         <= if_pc4;
      id_rs_data     <= rf_read(rs_idx);
      id_rt_data     <= rf_read(rt_idx);
      id_imm         <= dec_imm;
      id_shamt       <= if_inst[10:6];
      id_dst         <= dec_dst;
      id_alu_op      <= dec_alu_op;
      id_alu_src_imm <= dec_src_imm;
      id_mem_rd      <= dec_mem_rd;
      id_mem_wr      <= dec_mem_wr;
      id_reg_we      <= dec_reg_we;
      id_beq         <= dec_beq;
      id_bne         <= dec_bne;
      id_jump        <= dec_jump;
      id_jump_target <= {if_pc4[31:28], if_inst[25:0], 2'b00};
      id_illegal     <= dec_illegal;
      id_rs_idx      <= rs_idx;
      id_rt_idx      <= rt_idx;
    end
  end

endmodule
